// File: rtl/router_egress_sched_if.sv
// Shared 8-bit egress channel: byte plus packet tags, valid/ready handshake.
interface router_egress_sched_if;
  logic [7:0] egress_data;
  logic       egress_valid;
  logic       egress_ready;
  logic       egress_sop;
  logic       egress_eop;
  logic [1:0] egress_port;

  modport master (
    output egress_data, egress_valid, egress_sop, egress_eop, egress_port,
    input  egress_ready
  );

  modport slave (
    input  egress_data, egress_valid, egress_sop, egress_eop, egress_port,
    output egress_ready
  );
endinterface

// File: rtl/router_egress_sched.sv
// Round-robin packet-atomic scheduler from three router FIFOs onto one egress channel.
// Header reaches egress two cycles after vld_out; reads stall on skid-buffer credit when egress_ready is low.
module router_egress_sched (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out_0,
  input  logic       vld_out_1,
  input  logic       vld_out_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  router_egress_sched_if.master eg,
  output logic       hdr_err
);

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] port;
  } skid_ent_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_HWAIT = 3'd2;
  localparam logic [2:0] S_BODY  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0] state;
  logic [1:0] grant;
  logic [1:0] rr_ptr;
  logic [6:0] rem;

  skid_ent_t  mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       inflight;
  logic       infl_sop;
  logic       infl_eop;

  logic       grant_vld;
  logic [7:0] grant_dat;
  logic [2:0] vld_vec;
  logic       any_vld;
  logic [1:0] next_grant;
  logic       can_read;
  logic       rd_issue;
  logic       push_mem;
  logic       pop_mem;
  logic       out_vld;
  skid_ent_t  in_ent;
  skid_ent_t  out_ent;

  assign vld_vec = {vld_out_2, vld_out_1, vld_out_0};
  assign any_vld = |vld_vec;

  always_comb begin
    grant_vld = vld_out_2;
    grant_dat = data_out_2;
    case (grant)
      2'd0: begin grant_vld = vld_out_0; grant_dat = data_out_0; end
      2'd1: begin grant_vld = vld_out_1; grant_dat = data_out_1; end
      default: begin grant_vld = vld_out_2; grant_dat = data_out_2; end
    endcase
  end

  // first requesting port at or after rr_ptr, wrapping mod 3
  always_comb begin
    next_grant = rr_ptr;
    case (rr_ptr)
      2'd0:    next_grant = vld_vec[0] ? 2'd0 : (vld_vec[1] ? 2'd1 : 2'd2);
      2'd1:    next_grant = vld_vec[1] ? 2'd1 : (vld_vec[2] ? 2'd2 : 2'd0);
      default: next_grant = vld_vec[2] ? 2'd2 : (vld_vec[0] ? 2'd0 : 2'd1);
    endcase
  end

  // credit = 2 - occupancy - inflight must be positive
  assign can_read = (count == 2'd0) || ((count == 2'd1) && !inflight);
  assign rd_issue = ((state == S_HDR) || (state == S_BODY)) && grant_vld && can_read;

  assign read_enb_0 = rd_issue && (grant == 2'd0);
  assign read_enb_1 = rd_issue && (grant == 2'd1);
  assign read_enb_2 = rd_issue && (grant == 2'd2);

  assign hdr_err = (state == S_HWAIT) && (grant_dat[1:0] != grant);

  always_comb begin
    in_ent = '{data: grant_dat, sop: infl_sop, eop: infl_eop, port: grant};
  end

  // an empty buffer passes the landing byte straight through
  always_comb begin
    out_ent = mem[rd_ptr];
    if ((count == 2'd0) && inflight) begin
      out_ent = in_ent;
    end
  end

  assign out_vld         = (count != 2'd0) || inflight;
  assign eg.egress_valid = out_vld;
  assign eg.egress_data  = out_ent.data;
  assign eg.egress_sop   = out_vld && out_ent.sop;
  assign eg.egress_eop   = out_vld && out_ent.eop;
  assign eg.egress_port  = out_ent.port;

  assign push_mem = inflight && !((count == 2'd0) && eg.egress_ready);
  assign pop_mem  = (count != 2'd0) && eg.egress_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      grant    <= 2'd0;
      rr_ptr   <= 2'd0;
      rem      <= 7'd0;
      inflight <= 1'b0;
      infl_sop <= 1'b0;
      infl_eop <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else begin
      inflight <= rd_issue;
      infl_sop <= (state == S_HDR);
      infl_eop <= (state == S_BODY) && (rem == 7'd1);

      if (push_mem) begin
        mem[wr_ptr] <= in_ent;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_mem) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push_mem} - {1'b0, pop_mem};

      case (state)
        S_IDLE: begin
          if (any_vld) begin
            grant <= next_grant;
            state <= S_HDR;
          end
        end
        S_HDR: begin
          if (rd_issue) begin
            state <= S_HWAIT;
          end
        end
        S_HWAIT: begin
          rem   <= {1'b0, grant_dat[7:2]} + 7'd1;
          state <= S_BODY;
        end
        S_BODY: begin
          if (rd_issue) begin
            rem <= rem - 7'd1;
            if (rem == 7'd1) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((count == 2'd0) && !inflight) begin
            rr_ptr <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_egress_sched.sv
// Directed bench: FIFO models feed the scheduler, egress bytes are scoreboarded against hand-built packets.
module tb_router_egress_sched;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       hdr_err;

  always #5 clock = ~clock;

  router_egress_sched_if eg_if();

  router_egress_sched dut (
    .clock      (clock),
    .reset      (reset),
    .vld_out_0  (vld_out_0),
    .vld_out_1  (vld_out_1),
    .vld_out_2  (vld_out_2),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .read_enb_0 (read_enb_0),
    .read_enb_1 (read_enb_1),
    .read_enb_2 (read_enb_2),
    .eg         (eg_if),
    .hdr_err    (hdr_err)
  );

  logic [7:0]  fq0[$], fq1[$], fq2[$];
  logic [11:0] exp_q[$], got_q[$];

  int n_chk, n_bad, cyc, start;
  int nsop, neop, nerr, err_cyc, first_rd, first_vld, issued, accepted;
  logic [2:0] rd_mask;
  bit onehot_ok, stab_ok, buf_ok, bp_mode;
  logic pv, pr;
  logic [11:0] pent;
  logic smp_valid, smp_sop, smp_eop, smp_err;
  logic [7:0] smp_data;
  logic [1:0] smp_port;
  logic [2:0] smp_rd;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh_vld();
    vld_out_0 = (fq0.size() != 0);
    vld_out_1 = (fq1.size() != 0);
    vld_out_2 = (fq2.size() != 0);
  endtask

  task automatic push_fifo(input int port, input logic [7:0] b);
    case (port)
      0: fq0.push_back(b);
      1: fq1.push_back(b);
      default: fq2.push_back(b);
    endcase
  endtask

  // header, len payload bytes, XOR parity; expected tags recorded in call order
  task automatic load_pkt(input int port, input logic [7:0] hdr, input logic [7:0] seed);
    logic [7:0] par, b;
    logic [1:0] p;
    p   = port[1:0];
    par = hdr;
    push_fifo(port, hdr);
    exp_q.push_back({hdr, 1'b1, 1'b0, p});
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      b = seed + i[7:0];
      par = par ^ b;
      push_fifo(port, b);
      exp_q.push_back({b, 1'b0, 1'b0, p});
    end
    push_fifo(port, par);
    exp_q.push_back({par, 1'b0, 1'b1, p});
    refresh_vld();
  endtask

  task automatic clr_stats();
    exp_q.delete();
    got_q.delete();
    nsop = 0; neop = 0; nerr = 0; err_cyc = -1;
    first_rd = -1; first_vld = -1; issued = 0; accepted = 0;
    rd_mask = 3'b000; onehot_ok = 1; stab_ok = 1; buf_ok = 1; pv = 1'b0;
  endtask

  task automatic tick();
    logic [11:0] ent;
    @(negedge clock);
    smp_rd    = {read_enb_2, read_enb_1, read_enb_0};
    smp_valid = eg_if.egress_valid;
    smp_data  = eg_if.egress_data;
    smp_sop   = eg_if.egress_sop;
    smp_eop   = eg_if.egress_eop;
    smp_port  = eg_if.egress_port;
    smp_err   = hdr_err;
    ent = {smp_data, smp_sop, smp_eop, smp_port};
    if ($countones(smp_rd) > 1) onehot_ok = 0;
    rd_mask = rd_mask | smp_rd;
    if (smp_rd != 3'b000 && first_rd < 0) first_rd = cyc;
    if (smp_valid && first_vld < 0) first_vld = cyc;
    if (smp_err) begin nerr++; err_cyc = cyc; end
    if (pv && !pr && (!smp_valid || ent != pent)) stab_ok = 0;
    if (issued - accepted > 2) buf_ok = 0;
    if (smp_valid && eg_if.egress_ready) begin
      got_q.push_back(ent);
      if (smp_sop) nsop++;
      if (smp_eop) neop++;
    end
    pv = smp_valid; pr = eg_if.egress_ready; pent = ent;
    @(posedge clock);
    if (smp_rd != 3'b000) issued++;
    if (smp_valid && pr) accepted++;
    #1;
    if (smp_rd[0] && fq0.size() > 0) data_out_0 = fq0.pop_front();
    if (smp_rd[1] && fq1.size() > 0) data_out_1 = fq1.pop_front();
    if (smp_rd[2] && fq2.size() > 0) data_out_2 = fq2.pop_front();
    refresh_vld();
    cyc++;
    eg_if.egress_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
  endtask

  task automatic run_pkts(input int max_cyc);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < max_cyc) begin
      tick();
      n++;
    end
    repeat (6) tick();
  endtask

  task automatic compare(input string tag);
    chk($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s_byte%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
    end
  endtask

  initial begin
    n_chk = 0; n_bad = 0; cyc = 0; bp_mode = 0;
    data_out_0 = 8'h00; data_out_1 = 8'h00; data_out_2 = 8'h00;
    eg_if.egress_ready = 1'b1;
    refresh_vld();
    clr_stats();

    reset = 1'b1;
    tick(); tick();
    chk("rst_valid", int'(smp_valid), 0);
    chk("rst_sop",   int'(smp_sop), 0);
    chk("rst_eop",   int'(smp_eop), 0);
    chk("rst_err",   int'(smp_err), 0);
    chk("rst_data",  int'(smp_data), 0);
    chk("rst_port",  int'(smp_port), 0);
    chk("rst_rd",    int'(smp_rd), 0);
    reset = 1'b0;
    tick();

    // single packet on port 1
    clr_stats();
    start = cyc;
    load_pkt(1, 8'h11, 8'hA0);
    run_pkts(60);
    chk("t1_rd_lat",  first_rd - start, 1);
    chk("t1_vld_lat", first_vld - start, 2);
    compare("t1");
    chk("t1_rdmask", int'(rd_mask), 3'b010);
    chk("t1_err",    nerr, 0);
    chk("t1_onehot", int'(onehot_ok), 1);

    // all three FIFOs at once after reset, port 0 refilled
    reset = 1'b1; tick(); reset = 1'b0; tick();
    clr_stats();
    load_pkt(0, 8'h0C, 8'h10);
    load_pkt(1, 8'h05, 8'h20);
    load_pkt(2, 8'h0E, 8'h30);
    load_pkt(0, 8'h08, 8'h40);
    run_pkts(200);
    compare("t2");
    chk("t2_sop",    nsop, 4);
    chk("t2_eop",    neop, 4);
    chk("t2_err",    nerr, 0);
    chk("t2_onehot", int'(onehot_ok), 1);

    // backpressure with ready 1,0,0 repeating
    clr_stats();
    bp_mode = 1;
    load_pkt(0, 8'h20, 8'h50);
    run_pkts(200);
    bp_mode = 0;
    compare("t3");
    chk("t3_stable", int'(stab_ok), 1);
    chk("t3_buffer", int'(buf_ok), 1);

    // zero-length payload on port 2
    clr_stats();
    load_pkt(2, 8'h02, 8'h00);
    run_pkts(40);
    compare("t4");
    chk("t4_sop", nsop, 1);
    chk("t4_eop", neop, 1);

    // addr 3 header on port 0 flags an error but still forwards
    clr_stats();
    start = cyc;
    load_pkt(0, 8'h0B, 8'h60);
    run_pkts(40);
    chk("t5_err_cnt", nerr, 1);
    chk("t5_err_cyc", err_cyc - start, 2);
    compare("t5");

    // reset in BODY with 3 reads left on port 0
    clr_stats();
    load_pkt(0, 8'h18, 8'h70);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fq0.delete(); fq1.delete(); fq2.delete();
    refresh_vld();
    tick();
    chk("t6_valid", int'(smp_valid), 0);
    chk("t6_rd",    int'(smp_rd), 0);
    chk("t6_eop",   neop, 0);

    // rr_ptr back at 0: port 0 wins over port 1
    clr_stats();
    load_pkt(0, 8'h04, 8'h80);
    load_pkt(1, 8'h15, 8'h90);
    run_pkts(80);
    compare("t6r");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
